mult_adder_ctrl: RTL and testbench

MULT_ADDER_CTRL -- requirements
Module: mult_adder_ctrl

---
 rtl/mult_adder_ctrl_pkg.sv | 20 ++
 rtl/mult_adder_ctrl_fifo.sv | 54 +++++
 rtl/mult_adder_ctrl.sv | 147 ++++++++++++++
 tb/tb_mult_adder_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_adder_ctrl_pkg.sv
// Shared network parameters for the mult_adder controller: FSM state encoding
// and default geometry/latency constants.
package mult_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_IMG_W       = 8;
  localparam int DEF_IMG_H       = 8;
  localparam int DEF_KERNEL_SIZE = 3;
  localparam int DEF_STRIDE      = 1;
  localparam int DEF_MA_LATENCY  = 5;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_NN_WIDTH    = 16;

endpackage

// File: rtl/mult_adder_ctrl_fifo.sv
// Result buffer: synchronous first-word-fall-through FIFO with occupancy count
// and synchronous active-low reset.
module mult_adder_ctrl_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 17,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, wr_ok, rd_ok;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    rd_ok    = rd_en && !empty;
    wr_ok    = wr_en && (!full || rd_ok);
    wr_ptr_d = wr_ptr_q + AW'(wr_ok);
    rd_ptr_d = rd_ptr_q + AW'(rd_ok);
    count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
    // Storage is not reset, so the head is masked while empty.
    rd_data  = empty ? '0 : mem_q[rd_ptr_q];
    count    = count_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/mult_adder_ctrl.sv
// Window-issue / result-collection controller for a pipelined mult_adder.
// Optional MULT_ADDER_CTRL_RELU_EN clamps negative results to zero.
module mult_adder_ctrl
  import mult_adder_ctrl_pkg::*;
#(
  parameter int IMG_W       = DEF_IMG_W,
  parameter int IMG_H       = DEF_IMG_H,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int STRIDE      = DEF_STRIDE,
  parameter int MA_LATENCY  = DEF_MA_LATENCY,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int NN_WIDTH    = DEF_NN_WIDTH
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                win_req_valid,
  input  logic                win_req_ready,
  output logic [15:0]         win_row,
  output logic [15:0]         win_col,
  input  logic [NN_WIDTH-1:0] ma_result,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [NN_WIDTH-1:0] res_data,
  output logic                res_last
);

  localparam int NCOL     = (IMG_W - KERNEL_SIZE) / STRIDE + 1;
  localparam int NROW     = (IMG_H - KERNEL_SIZE) / STRIDE + 1;
  localparam int LAST_COL = (NCOL - 1) * STRIDE;
  localparam int LAST_ROW = (NROW - 1) * STRIDE;
  localparam int MAX_COL  = IMG_W - KERNEL_SIZE;
  localparam int CNTW     = $clog2(FIFO_DEPTH) + 1;
  localparam int IFW      = $clog2(MA_LATENCY + 1);

  state_e                state_q, state_d;
  logic [15:0]           row_q, row_d, col_q, col_d;
  logic [IFW-1:0]        in_flight_q, in_flight_d;
  logic [MA_LATENCY-1:0] vld_sr_q, vld_sr_d, last_sr_q, last_sr_d;

  logic                  credit_ok, issue, final_win, tail, pop;
  logic [NN_WIDTH-1:0]   result_w;
  logic [NN_WIDTH:0]     fifo_wdata, fifo_rdata;
  logic                  fifo_empty;
  logic [CNTW-1:0]       fifo_count;

  always_comb begin
    credit_ok     = (32'(in_flight_q) + 32'(fifo_count)) < 32'(FIFO_DEPTH);
    win_req_valid = (state_q == ST_RUN) && credit_ok;
    issue         = win_req_valid && win_req_ready;
    final_win     = (row_q == 16'(LAST_ROW)) && (col_q == 16'(LAST_COL));
    win_row       = row_q;
    win_col       = col_q;
    res_valid     = !fifo_empty;
    {res_last, res_data} = fifo_rdata;
    pop           = res_valid && res_ready;
    busy          = (state_q != ST_IDLE);
    done          = (state_q == ST_DONE);

    vld_sr_d[0]  = issue;
    last_sr_d[0] = issue && final_win;
    for (int unsigned i = 1; i < MA_LATENCY; i++) begin
      vld_sr_d[i]  = vld_sr_q[i-1];
      last_sr_d[i] = last_sr_q[i-1];
    end
    tail        = vld_sr_q[MA_LATENCY-1];
    in_flight_d = in_flight_q + IFW'(issue) - IFW'(tail);

`ifdef MULT_ADDER_CTRL_RELU_EN
    result_w = ma_result[NN_WIDTH-1] ? '0 : ma_result;
`else
    result_w = ma_result;
`endif
    fifo_wdata = {last_sr_q[MA_LATENCY-1], result_w};
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ST_RUN: begin
        if (issue) begin
          if (final_win) begin
            state_d = ST_DRAIN;
            row_d   = '0;
            col_d   = '0;
          end else if ((32'(col_q) + 32'(STRIDE)) > 32'(MAX_COL)) begin
            col_d = '0;
            row_d = row_q + 16'(STRIDE);
          end else begin
            col_d = col_q + 16'(STRIDE);
          end
        end
      end
      // Leave one cycle early when the last buffered word is popped now,
      // so done lands in the cycle right after that pop.
      ST_DRAIN: begin
        if ((in_flight_q == '0) && (fifo_count == CNTW'(pop))) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      in_flight_q <= '0;
      vld_sr_q    <= '0;
      last_sr_q   <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      in_flight_q <= in_flight_d;
      vld_sr_q    <= vld_sr_d;
      last_sr_q   <= last_sr_d;
    end
  end

  mult_adder_ctrl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NN_WIDTH + 1)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (tail),
    .wr_data (fifo_wdata),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_mult_adder_ctrl.sv
// Scoreboard bench for mult_adder_ctrl: three instances (4x4/S1, 5x5/S2, 8x8/S1)
// sharing one clock and one ma_result stream derived from the cycle count.
module tb_mult_adder_ctrl;

  localparam int LAT = 5;

  logic        clock = 1'b0;
  logic [2:0]  rst_n, start, wrr, rr;
  logic [2:0]  busy_w, done_w, wrv, rv, rl;
  logic [15:0] wrow [3];
  logic [15:0] wcol [3];
  logic [15:0] rdata [3];
  logic [15:0] ma_res;
  int          cyc = 0;

  int          checks = 0;
  int          failures = 0;
  int          k [3], pops [3], issue_tot [3], done_cnt [3];
  logic        done_exp [3], hold_v [3];
  logic [31:0] held [3];
  logic [16:0] sb_q [3][$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [15:0] ma_model(input int c);
    logic [31:0] v;
    v = 32'(c * 5 + 1);
    return (c % 3 == 0) ? 16'hFFFB : v[15:0];
  endfunction

  function automatic logic [15:0] exp_res(input int c);
    logic [15:0] raw;
    raw = ma_model(c);
`ifdef MULT_ADDER_CTRL_RELU_EN
    if (raw[15]) raw = 16'h0000;
`endif
    return raw;
  endfunction

  assign ma_res = ma_model(cyc);

  function automatic int img_dim(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 5 : 8);
  endfunction
  function automatic int stride_of(input int i);
    return (i == 1) ? 2 : 1;
  endfunction
  function automatic int ncol(input int i);
    return (img_dim(i) - 3) / stride_of(i) + 1;
  endfunction
  function automatic int nwin(input int i);
    return ncol(i) * ncol(i);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    mult_adder_ctrl #(
      .IMG_W       ((g == 0) ? 4 : ((g == 1) ? 5 : 8)),
      .IMG_H       ((g == 0) ? 4 : ((g == 1) ? 5 : 8)),
      .KERNEL_SIZE (3),
      .STRIDE      ((g == 1) ? 2 : 1),
      .MA_LATENCY  (LAT),
      .FIFO_DEPTH  (4),
      .NN_WIDTH    (16)
    ) u_dut (
      .clock         (clock),
      .reset         (rst_n[g]),
      .start         (start[g]),
      .busy          (busy_w[g]),
      .done          (done_w[g]),
      .win_req_valid (wrv[g]),
      .win_req_ready (wrr[g]),
      .win_row       (wrow[g]),
      .win_col       (wcol[g]),
      .ma_result     (ma_res),
      .res_valid     (rv[g]),
      .res_ready     (rr[g]),
      .res_data      (rdata[g]),
      .res_last      (rl[g])
    );
  end

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        if (!rst_n[i]) begin
          sb_q[i].delete();
          k[i] = 0;
          pops[i] = 0;
          done_exp[i] = 1'b0;
          hold_v[i] = 1'b0;
        end else begin
          chk_eq("done_pulse", 32'(done_w[i]), 32'(done_exp[i]));
          done_exp[i] = 1'b0;
          if (done_w[i]) begin
            chk_eq("pass_windows", 32'(k[i]), 32'(nwin(i)));
            chk_eq("pass_results", 32'(pops[i]), 32'(nwin(i)));
            chk_eq("sb_empty_at_done", 32'(sb_q[i].size()), 32'd0);
            k[i] = 0;
            pops[i] = 0;
            done_cnt[i]++;
          end
          if (hold_v[i] && wrv[i])
            chk_eq("win_hold", {wrow[i], wcol[i]}, held[i]);
          hold_v[i] = wrv[i] && !wrr[i];
          held[i]   = {wrow[i], wcol[i]};
          if (wrv[i] && wrr[i]) begin
            chk_eq("win_row", 32'(wrow[i]), 32'((k[i] / ncol(i)) * stride_of(i)));
            chk_eq("win_col", 32'(wcol[i]), 32'((k[i] % ncol(i)) * stride_of(i)));
            sb_q[i].push_back({(k[i] == nwin(i) - 1), exp_res(cyc + LAT)});
            k[i]++;
            issue_tot[i]++;
          end
          if (rv[i] && rr[i]) begin
            if (sb_q[i].size() == 0) begin
              chk_eq("res_spurious", 32'(rv[i]), 32'd0);
            end else begin
              logic [16:0] e;
              e = sb_q[i].pop_front();
              chk_eq("res_data", 32'(rdata[i]), 32'(e[15:0]));
              chk_eq("res_last", 32'(rl[i]), 32'(e[16]));
              pops[i]++;
              if (rl[i]) done_exp[i] = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
  endtask

  task automatic check_idle(input int i);
    chk_eq("idle_busy", 32'(busy_w[i]), 32'd0);
    chk_eq("idle_done", 32'(done_w[i]), 32'd0);
    chk_eq("idle_win_valid", 32'(wrv[i]), 32'd0);
    chk_eq("idle_res_valid", 32'(rv[i]), 32'd0);
    chk_eq("idle_res_last", 32'(rl[i]), 32'd0);
    chk_eq("idle_res_data", 32'(rdata[i]), 32'd0);
    chk_eq("idle_win_pos", {wrow[i], wcol[i]}, 32'd0);
  endtask

  task automatic wait_done(input int i, input int budget, input bit rand_ready);
    int base;
    int n;
    base = done_cnt[i];
    n = 0;
    while (done_cnt[i] == base && n < budget) begin
      if (rand_ready) wrr[i] = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    wrr[i] = 1'b1;
    chk_eq("wait_done", 32'(done_cnt[i]), 32'(base + 1));
  endtask

  initial begin
    int base;
    int n;
    rst_n = '0;
    start = '0;
    wrr   = 3'b111;
    rr    = 3'b111;
    for (int i = 0; i < 3; i++) begin
      k[i] = 0; pops[i] = 0; issue_tot[i] = 0; done_cnt[i] = 0;
      done_exp[i] = 1'b0; hold_v[i] = 1'b0; held[i] = '0;
    end
    fork
      monitor();
    join_none

    repeat (2) tick();
    for (int i = 0; i < 3; i++) check_idle(i);
    rst_n = '1;
    tick();

    // 4x4, K=3, S=1: four windows, one done
    pulse_start(0);
    wait_done(0, 300, 1'b0);
    chk_eq("a_done_count", 32'(done_cnt[0]), 32'd1);

    // 5x5, S=2 with stalling ready; a second start during RUN must be ignored
    pulse_start(1);
    tick();
    pulse_start(1);
    wait_done(1, 400, 1'b1);
    repeat (10) tick();
    chk_eq("b_single_done", 32'(done_cnt[1]), 32'd1);

    // 8x8 with res_ready held low: credit limit of FIFO_DEPTH issues
    rr[2] = 1'b0;
    base = issue_tot[2];
    pulse_start(2);
    repeat (40) tick();
    chk_eq("c_credit_issues", 32'(issue_tot[2] - base), 32'd4);
    chk_eq("c_credit_valid", 32'(wrv[2]), 32'd0);
    chk_eq("c_res_valid", 32'(rv[2]), 32'd1);
    rr[2] = 1'b1;
    wait_done(2, 1000, 1'b0);
    chk_eq("c_done_count", 32'(done_cnt[2]), 32'd1);

    // Reset after three issues, then a fresh pass from (0,0)
    base = issue_tot[0];
    pulse_start(0);
    n = 0;
    while ((issue_tot[0] - base) < 3 && n < 100) begin
      tick();
      n++;
    end
    chk_eq("r_issues_before_reset", 32'(issue_tot[0] - base), 32'd3);
    rst_n[0] = 1'b0;
    tick();
    check_idle(0);
    rst_n[0] = 1'b1;
    repeat (12) tick();
    chk_eq("r_no_res_valid", 32'(rv[0]), 32'd0);
    chk_eq("r_not_busy", 32'(busy_w[0]), 32'd0);
    chk_eq("r_issue_total", 32'(issue_tot[0] - base), 32'd3);
    pulse_start(0);
    wait_done(0, 300, 1'b0);
    chk_eq("r_done_count", 32'(done_cnt[0]), 32'd2);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
